sop_sweep: RTL and testbench

Parametrised sum-of-products sweep engine: holds N_OUT programmable minterm masks over N_IN variables and, on command, steps through all 2^N_IN input combinations in ascending order. For each combination it streams the evaluated function outputs over a valid/ready interface. It is the sequential, generalised successor of our fixed 4-input/3-output SoP blocks. It replaces the hand-written stimulus sweep used in truth-table benches and serves as a reusable truth-table generator inside larger designs.

---
 rtl/sop_sweep.sv | 204 ++++++++++++++++++++
 tb/tb_sop_sweep.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sop_sweep.sv
// sop_sweep: programmable sum-of-products truth-table sweep engine.
// Holds N_OUT minterm masks over N_IN variables. On start it walks every
// input combination in ascending order and streams the evaluated functions
// over a valid/ready handshake.
// Optional feature: define SOP_SWEEP_CNT_EN to add the ones_cnt port, which
// holds per-function counts of rows evaluating to 1 in the current sweep.
module sop_sweep #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3,
    parameter int SW    = (N_OUT > 32'sd1) ? $clog2(N_OUT) : 32'sd1,
    localparam int ROWS = 32'sd1 << N_IN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [SW-1:0]     cfg_sel,
    input  logic [ROWS-1:0]   cfg_mask,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_IN-1:0]   out_idx,
    output logic [N_OUT-1:0]  out_f
`ifdef SOP_SWEEP_CNT_EN
    ,
    output logic [N_OUT*(N_IN+1)-1:0] ones_cnt
`endif
);

    localparam logic [N_IN-1:0] IDX_ZERO = {N_IN{1'b0}};
    localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [N_IN-1:0]   idx_r;
    logic [ROWS-1:0]   mask_r [N_OUT];
    logic [31:0]       sel_ext_s;
    logic              cfg_ok_s;
    logic              start_ok_s;
    logic              accept_s;
    logic              last_row_s;

    // Qualify commands: config writes and start only take effect while idle,
    // and a selector beyond the last function is dropped.
    always_comb begin
        sel_ext_s  = 32'(cfg_sel);
        cfg_ok_s   = cfg_we && (state_r == ST_IDLE) && (sel_ext_s < 32'(N_OUT));
        start_ok_s = start && (state_r == ST_IDLE);
        accept_s   = (state_r == ST_RUN) && out_ready;
        last_row_s = (idx_r == IDX_LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: the sweep leaves RUN only once the last row is taken.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (out_ready && last_row_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Status outputs decoded purely from the registered state.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy      = 1'b0;
                done      = 1'b0;
                out_valid = 1'b0;
            end
            ST_RUN: begin
                busy      = 1'b1;
                done      = 1'b0;
                out_valid = 1'b1;
            end
            ST_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                out_valid = 1'b0;
            end
            default: begin
                busy      = 1'b0;
                done      = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Row index: cleared on start, advanced per accepted row, never wraps;
    // it stays on the last row through DONE and IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_r <= IDX_ZERO;
        end else if (start_ok_s) begin
            idx_r <= IDX_ZERO;
        end else if (accept_s && !last_row_s) begin
            idx_r <= idx_r + IDX_ONE;
        end else begin
            idx_r <= idx_r;
        end
    end

    // Minterm mask storage; writes land on the same edge as a start, so a
    // sweep launched together with a write already sees the new mask.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < N_OUT; k++) begin
                mask_r[k] <= {ROWS{1'b0}};
            end
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (cfg_ok_s && (sel_ext_s == 32'(k))) begin
                    mask_r[k] <= cfg_mask;
                end else begin
                    mask_r[k] <= mask_r[k];
                end
            end
        end
    end

    // Function evaluation: each output is its mask bit selected by the row.
    always_comb begin
        out_idx = idx_r;
        out_f   = {N_OUT{1'b0}};
        for (int k = 0; k < N_OUT; k++) begin
            out_f[k] = mask_r[k][idx_r];
        end
    end

`ifdef SOP_SWEEP_CNT_EN
    localparam int                CNT_W   = N_IN + 1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1'b1);

    logic [CNT_W-1:0] cnt_r [N_OUT];

    // Ones counters: cleared when a sweep starts, bumped per accepted row
    // whose function value is 1, then held until the next start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < N_OUT; k++) begin
                cnt_r[k] <= {CNT_W{1'b0}};
            end
        end else if (start_ok_s) begin
            for (int k = 0; k < N_OUT; k++) begin
                cnt_r[k] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (accept_s && out_f[k]) begin
                    cnt_r[k] <= cnt_r[k] + CNT_ONE;
                end else begin
                    cnt_r[k] <= cnt_r[k];
                end
            end
        end
    end

    // Pack the counters, function 0 in the least significant field.
    always_comb begin
        ones_cnt = {(N_OUT*CNT_W){1'b0}};
        for (int k = 0; k < N_OUT; k++) begin
            ones_cnt[k*CNT_W +: CNT_W] = cnt_r[k];
        end
    end
`endif

endmodule

// File: tb/tb_sop_sweep.sv
// Self-checking bench for sop_sweep: default 4-in/3-out instance plus a
// 2-in/1-out instance, compared against a mask-table reference model.
`timescale 1ns/1ps
module tb_sop_sweep;
    localparam int N_IN  = 4;
    localparam int N_OUT = 3;
    localparam int SW    = 2;
    localparam int ROWS  = 16;
    localparam int CNT_W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, cfg_we, start, out_ready;
    logic [SW-1:0]     cfg_sel;
    logic [ROWS-1:0]   cfg_mask;
    logic              busy, done, out_valid;
    logic [N_IN-1:0]   out_idx;
    logic [N_OUT-1:0]  out_f;
    logic [N_OUT*CNT_W-1:0] ones_cnt;
    logic [N_OUT*CNT_W-1:0] done_cnt;

    logic        s_rst_n, s_cfg_we, s_start, s_ready;
    logic [0:0]  s_cfg_sel;
    logic [3:0]  s_cfg_mask;
    logic        s_busy, s_done, s_valid;
    logic [1:0]  s_idx;
    logic [0:0]  s_f;
    logic [2:0]  s_cnt;

    sop_sweep #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_mask(cfg_mask), .start(start), .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_f(out_f)
`ifdef SOP_SWEEP_CNT_EN
        , .ones_cnt(ones_cnt)
`endif
    );

    sop_sweep #(.N_IN(2), .N_OUT(1)) dut_small (
        .clk(clk), .rst_n(s_rst_n), .cfg_we(s_cfg_we), .cfg_sel(s_cfg_sel),
        .cfg_mask(s_cfg_mask), .start(s_start), .busy(s_busy), .done(s_done),
        .out_valid(s_valid), .out_ready(s_ready), .out_idx(s_idx),
        .out_f(s_f)
`ifdef SOP_SWEEP_CNT_EN
        , .ones_cnt(s_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the programmed mask table.
    logic [ROWS-1:0] m_mask [N_OUT];

    // Observations from the most recent sweep.
    int acc_idx[$];
    int acc_f[$];
    int pres_idx[$];
    int run_cycles;
    bit timed_out, aborted;
    logic first_valid, first_busy, done_valid, done_busy, post_busy, post_done;
    logic [N_IN-1:0] first_idx;

    function automatic logic [N_OUT-1:0] model_f(input int row);
        logic [N_OUT-1:0] r;
        for (int k = 0; k < N_OUT; k++) r[k] = m_mask[k][row];
        return r;
    endfunction

    function automatic int popcnt(input logic [ROWS-1:0] v);
        int c = 0;
        for (int b = 0; b < ROWS; b++) if (v[b]) c++;
        return c;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write_mask(input logic [SW-1:0] sel, input logic [ROWS-1:0] m);
        cfg_we = 1'b1; cfg_sel = sel; cfg_mask = m;
        tick();
        cfg_we = 1'b0;
        if (int'(sel) < N_OUT) m_mask[int'(sel)] = m;
    endtask

    // Drive one sweep and record what the DUT presented.
    // mode 0: ready high, 1: stall at stall_at for stall_len cycles, 2: random ready.
    task automatic run_sweep(input int mode, input int stall_at, input int stall_len,
                             input int inject_at, input int abort_at, input bit sim_we,
                             input logic [SW-1:0] sim_sel, input logic [ROWS-1:0] sim_mask);
        int stalls = 0;
        bit injected = 1'b0;
        int guard = 0;
        acc_idx.delete(); acc_f.delete(); pres_idx.delete();
        timed_out = 1'b0; aborted = 1'b0; run_cycles = 0;
        start = 1'b1; cfg_we = sim_we; cfg_sel = sim_sel; cfg_mask = sim_mask; out_ready = 1'b1;
        tick();
        start = 1'b0; cfg_we = 1'b0;
        first_valid = out_valid; first_busy = busy; first_idx = out_idx;
        while (done !== 1'b1) begin
            if (guard >= 400) begin
                timed_out = 1'b1;
                break;
            end
            guard++;
            start = 1'b0; cfg_we = 1'b0;
            if (abort_at >= 0 && int'(out_idx) == abort_at) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                aborted = 1'b1;
                break;
            end
            pres_idx.push_back(int'(out_idx));
            if (mode == 1 && int'(out_idx) == stall_at && stalls < stall_len) begin
                out_ready = 1'b0;
                stalls++;
            end else if (mode == 2) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
            if (inject_at >= 0 && int'(out_idx) == inject_at && !injected) begin
                start = 1'b1; cfg_we = 1'b1; cfg_sel = {SW{1'b0}}; cfg_mask = {ROWS{1'b1}};
                injected = 1'b1;
            end
            if (out_valid === 1'b1 && out_ready) begin
                acc_idx.push_back(int'(out_idx));
                acc_f.push_back(int'(out_f));
            end
            tick();
            run_cycles++;
        end
        start = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
        if (!timed_out && !aborted) begin
            done_valid = out_valid; done_busy = busy; done_cnt = ones_cnt;
            tick();
            post_busy = busy; post_done = done;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_rst_n = 1'b0;
        tick(); tick();
        n_checks++; if ({busy, done, out_valid} !== 3'b000) $display("FAIL reset_status: got %b want 000", {busy, done, out_valid}); else n_pass++;
        n_checks++; if (out_idx !== 4'd0) $display("FAIL reset_idx: got %0d want 0", out_idx); else n_pass++;
        n_checks++; if (out_f !== 3'b000) $display("FAIL reset_f: got %b want 000", out_f); else n_pass++;
        n_checks++; if ({s_busy, s_done, s_valid, s_f} !== 4'b0000) $display("FAIL reset_small: got %b want 0000", {s_busy, s_done, s_valid, s_f}); else n_pass++;
        rst_n = 1'b1; s_rst_n = 1'b1;
        run_sweep(0, -1, 0, -1, -1, 1'b0, {SW{1'b0}}, {ROWS{1'b0}});
        n_checks++; if (acc_f.size() != 16) $display("FAIL zero_rows: got %0d want 16", acc_f.size()); else n_pass++;
        for (int i = 0; i < acc_f.size(); i++) begin
            n_checks++; if (acc_f[i] != 0) $display("FAIL zero_f row %0d: got %0d want 0", i, acc_f[i]); else n_pass++;
        end
    endtask

    task automatic test_known_masks();
        int spec_idx[5] = '{1, 2, 9, 13, 15};
        int spec_f[5]   = '{5, 7, 3, 4, 0};
        write_mask(2'd0, 16'h5266);
        write_mask(2'd1, 16'h16C5);
        write_mask(2'd2, 16'h20AE);
        run_sweep(0, -1, 0, -1, -1, 1'b0, {SW{1'b0}}, {ROWS{1'b0}});
        n_checks++; if ({first_valid, first_busy, first_idx} !== 6'b110000) $display("FAIL first_row: got %b want 110000", {first_valid, first_busy, first_idx}); else n_pass++;
        n_checks++; if (acc_f.size() != 16) $display("FAIL known_rows: got %0d want 16", acc_f.size()); else n_pass++;
        for (int i = 0; i < acc_f.size(); i++) begin
            n_checks++;
            if (acc_idx[i] != i || acc_f[i] != int'(model_f(i)))
                $display("FAIL known_row %0d: got idx %0d f %0d want idx %0d f %0d", i, acc_idx[i], acc_f[i], i, model_f(i));
            else n_pass++;
        end
        if (acc_f.size() == 16) begin
            for (int j = 0; j < 5; j++) begin
                n_checks++; if (acc_f[spec_idx[j]] != spec_f[j]) $display("FAIL spec_point idx %0d: got %0d want %0d", spec_idx[j], acc_f[spec_idx[j]], spec_f[j]); else n_pass++;
            end
        end
        n_checks++; if (run_cycles != 16) $display("FAIL run_cycles: got %0d want 16", run_cycles); else n_pass++;
        n_checks++; if ({done_valid, done_busy} !== 2'b01) $display("FAIL done_cycle: got %b want 01", {done_valid, done_busy}); else n_pass++;
        n_checks++; if ({post_busy, post_done} !== 2'b00) $display("FAIL after_done: got %b want 00", {post_busy, post_done}); else n_pass++;
`ifdef SOP_SWEEP_CNT_EN
        n_checks++; if (done_cnt !== {5'd6, 5'd7, 5'd7}) $display("FAIL ones_cnt: got %h want %h", done_cnt, {5'd6, 5'd7, 5'd7}); else n_pass++;
`endif
    endtask

    task automatic test_backpressure();
        int held = 0;
        run_sweep(1, 5, 3, -1, -1, 1'b0, {SW{1'b0}}, {ROWS{1'b0}});
        foreach (pres_idx[i]) if (pres_idx[i] == 5) held++;
        n_checks++; if (held != 4) $display("FAIL stall_hold: got %0d want 4", held); else n_pass++;
        n_checks++; if (acc_f.size() != 16) $display("FAIL stall_rows: got %0d want 16", acc_f.size()); else n_pass++;
        for (int i = 0; i < acc_f.size(); i++) begin
            n_checks++;
            if (acc_idx[i] != i || acc_f[i] != int'(model_f(i)))
                $display("FAIL stall_row %0d: got idx %0d f %0d want idx %0d f %0d", i, acc_idx[i], acc_f[i], i, model_f(i));
            else n_pass++;
        end
        n_checks++; if (run_cycles != 19) $display("FAIL stall_cycles: got %0d want 19", run_cycles); else n_pass++;
    endtask

    task automatic test_ignored_cmds();
        logic [ROWS-1:0] f0_vec;
        run_sweep(0, -1, 0, 7, -1, 1'b0, {SW{1'b0}}, {ROWS{1'b0}});
        n_checks++; if (acc_f.size() != 16) $display("FAIL ign_rows: got %0d want 16", acc_f.size()); else n_pass++;
        for (int i = 0; i < acc_f.size(); i++) begin
            n_checks++;
            if (acc_idx[i] != i || acc_f[i] != int'(model_f(i)))
                $display("FAIL ign_row %0d: got idx %0d f %0d want idx %0d f %0d", i, acc_idx[i], acc_f[i], i, model_f(i));
            else n_pass++;
        end
        n_checks++; if (run_cycles != 16) $display("FAIL ign_cycles: got %0d want 16", run_cycles); else n_pass++;
        n_checks++; if (post_busy !== 1'b0) $display("FAIL ign_restart: got busy %b want 0", post_busy); else n_pass++;
        run_sweep(0, -1, 0, -1, -1, 1'b0, {SW{1'b0}}, {ROWS{1'b0}});
        f0_vec = {ROWS{1'b0}};
        for (int i = 0; i < acc_f.size() && i < ROWS; i++) f0_vec[i] = acc_f[i][0];
        n_checks++; if (f0_vec !== 16'h5266) $display("FAIL ign_f0_mask: got %h want 5266", f0_vec); else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            logic [SW-1:0]   sel;
            logic [ROWS-1:0] m;
            write_mask(SW'($urandom_range(0, 3)), ROWS'($urandom));
            sel = SW'($urandom_range(0, 3));
            m   = ROWS'($urandom);
            if (int'(sel) < N_OUT) m_mask[int'(sel)] = m;
            run_sweep(2, -1, 0, -1, -1, 1'b1, sel, m);
            n_checks++; if (timed_out || acc_f.size() != 16) $display("FAIL rand_rows it %0d: got %0d timeout %0d want 16", it, acc_f.size(), timed_out); else n_pass++;
            for (int i = 0; i < acc_f.size(); i++) begin
                n_checks++;
                if (acc_idx[i] != i || acc_f[i] != int'(model_f(i)))
                    $display("FAIL rand_row it %0d row %0d: got idx %0d f %0d want idx %0d f %0d", it, i, acc_idx[i], acc_f[i], i, model_f(i));
                else n_pass++;
            end
`ifdef SOP_SWEEP_CNT_EN
            for (int k = 0; k < N_OUT; k++) begin
                n_checks++;
                if (int'(done_cnt[k*CNT_W +: CNT_W]) != popcnt(m_mask[k]))
                    $display("FAIL rand_cnt it %0d f%0d: got %0d want %0d", it, k, done_cnt[k*CNT_W +: CNT_W], popcnt(m_mask[k]));
                else n_pass++;
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        write_mask(2'd0, 16'h5266);
        write_mask(2'd1, 16'h16C5);
        write_mask(2'd2, 16'h20AE);
        run_sweep(0, -1, 0, -1, 10, 1'b0, {SW{1'b0}}, {ROWS{1'b0}});
        n_checks++; if (!aborted || acc_f.size() != 10) $display("FAIL abort_rows: got %0d aborted %0d want 10", acc_f.size(), aborted); else n_pass++;
        n_checks++; if ({busy, done, out_valid, out_idx, out_f} !== 10'd0) $display("FAIL abort_state: got %b want 0", {busy, done, out_valid, out_idx, out_f}); else n_pass++;
        for (int k = 0; k < N_OUT; k++) m_mask[k] = {ROWS{1'b0}};
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (done !== 1'b0) $display("FAIL abort_no_done cycle %0d: got %b want 0", c, done); else n_pass++;
        end
        write_mask(2'd3, 16'hFFFF);
        run_sweep(0, -1, 0, -1, -1, 1'b0, {SW{1'b0}}, {ROWS{1'b0}});
        n_checks++; if (acc_f.size() != 16) $display("FAIL cleared_rows: got %0d want 16", acc_f.size()); else n_pass++;
        for (int i = 0; i < acc_f.size(); i++) begin
            n_checks++; if (acc_f[i] != int'(model_f(i))) $display("FAIL cleared_row %0d: got %0d want %0d", i, acc_f[i], model_f(i)); else n_pass++;
        end
    endtask

    task automatic test_small();
        logic [1:0] ri;
        s_cfg_we = 1'b1; s_cfg_sel = 1'b0; s_cfg_mask = 4'b0110;
        tick();
        s_cfg_we = 1'b0; s_start = 1'b1; s_ready = 1'b1;
        tick();
        s_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ri = 2'(i);
            n_checks++;
            if ({s_valid, s_idx, s_f} !== {1'b1, ri, ri[1] ^ ri[0]})
                $display("FAIL small_row %0d: got %b want %b", i, {s_valid, s_idx, s_f}, {1'b1, ri, ri[1] ^ ri[0]});
            else n_pass++;
            tick();
        end
        n_checks++; if ({s_done, s_valid} !== 2'b10) $display("FAIL small_done: got %b want 10", {s_done, s_valid}); else n_pass++;
`ifdef SOP_SWEEP_CNT_EN
        n_checks++; if (s_cnt !== 3'd2) $display("FAIL small_cnt: got %0d want 2", s_cnt); else n_pass++;
`endif
        tick();
        n_checks++; if ({s_busy, s_done} !== 2'b00) $display("FAIL small_idle: got %b want 00", {s_busy, s_done}); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = {SW{1'b0}}; cfg_mask = {ROWS{1'b0}};
        start = 1'b0; out_ready = 1'b1;
        s_rst_n = 1'b0; s_cfg_we = 1'b0; s_cfg_sel = 1'b0; s_cfg_mask = 4'b0000;
        s_start = 1'b0; s_ready = 1'b1;
        done_cnt = '0;
`ifndef SOP_SWEEP_CNT_EN
        ones_cnt = '0;
        s_cnt = 3'd0;
`endif
        for (int k = 0; k < N_OUT; k++) m_mask[k] = {ROWS{1'b0}};
        test_reset();
        test_known_masks();
        test_backpressure();
        test_ignored_cmds();
        test_random();
        test_reset_mid();
        test_small();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
